// File: rtl/montgomery_pkg.sv
// Shared types and defaults for the radix-2 Montgomery multiplier.
package montgomery_pkg;
    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_CORR = 2'd2,
        ST_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/montgomery_step.sv
// One radix-2 Montgomery iteration: S' = (S + a_i*b + q*m) / 2 with q chosen to make the sum even.
module montgomery_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+1:0] s,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH+1:0] s_next
);
    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] u;

    // S < 2^(W+1) is invariant, so S + b + m always fits in W+2 bits.
    always_comb begin
        t      = s + (a_bit ? {2'b00, b} : '0);
        u      = t + (t[0] ? {2'b00, m} : '0);
        s_next = u >> 1;
    end
endmodule

// File: rtl/montgomery_mul_core.sv
// Bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod m, one bit of a per cycle.
module montgomery_mul_core
    import montgomery_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_r, b_r, m_r;
    logic [WIDTH+1:0] s, s_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result_r;
    logic             error_r;
    logic [WIDTH+1:0] s_sub;

    montgomery_step #(.WIDTH(WIDTH)) u_step (
        .s      (s),
        .a_bit  (a_r[cnt]),
        .b      (b_r),
        .m      (m_r),
        .s_next (s_next)
    );

    assign s_sub     = s - {2'b00, m_r};
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = result_r;
    assign error     = error_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            m_r      <= '0;
            s        <= '0;
            cnt      <= '0;
            result_r <= '0;
            error_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= b;
                        m_r <= m;
                        s   <= '0;
                        cnt <= '0;
                        // An even modulus has no inverse of 2; report it without iterating.
                        if (!m[0]) begin
                            result_r <= '0;
                            error_r  <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    s   <= s_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= ST_CORR;
                end
                ST_CORR: begin
                    result_r <= (s >= {2'b00, m_r}) ? s_sub[WIDTH-1:0] : s[WIDTH-1:0];
                    error_r  <= 1'b0;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
